// File: rtl/rf_pkg.sv
// Shared defaults and index/data types for the register file with pending-write scoreboard.
package rf_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_NUM_REGS = 4;
  localparam int DEF_MAX_PEND = 3;

  typedef logic [$clog2(DEF_NUM_REGS)-1:0] reg_idx_t;
  typedef logic [DEF_DATA_W-1:0]           data_t;

endpackage

// File: rtl/pend_counter.sv
// Per-register outstanding-write counter: floors at zero, refuses to pass MAX_PEND,
// and treats a simultaneous increment and decrement as no change.
module pend_counter #(
  parameter  int MAX_PEND = 3,
  localparam int CW       = $clog2(MAX_PEND + 1)
) (
  input  logic          clock,
  input  logic          clear,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          at_max,
  output logic          nonzero
);

  assign at_max  = (count == CW'(MAX_PEND));
  assign nonzero = (count != '0);

  // A writeback with nothing outstanding (e.g. issued before a reset) leaves the count at zero.
  always_ff @(posedge clock) begin
    if (clear) begin
      count <= '0;
    end else if (inc && !dec && !at_max) begin
      count <= count + CW'(1);
    end else if (dec && !inc && nonzero) begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file (r0 hardwired to zero) with per-register pending-write scoreboard for decode interlock.
// Optional feature macro: RF_BYPASS_EN (same-cycle writeback forwarding and early hazard release).
module regfile_scoreboard
  import rf_pkg::*;
#(
  parameter  int DATA_W   = DEF_DATA_W,
  parameter  int NUM_REGS = DEF_NUM_REGS,
  parameter  int MAX_PEND = DEF_MAX_PEND,
  localparam int AW       = $clog2(NUM_REGS),
  localparam int CW       = $clog2(MAX_PEND + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [AW-1:0]       rr1,
  input  logic [AW-1:0]       rr2,
  output logic [DATA_W-1:0]   rd1,
  output logic [DATA_W-1:0]   rd2,
  input  logic                regwrite,
  input  logic [AW-1:0]       wr,
  input  logic [DATA_W-1:0]   wd,
  input  logic                issue_valid,
  input  logic                issue_use_rs,
  input  logic                issue_use_rt,
  input  logic                issue_wen,
  input  logic [AW-1:0]       issue_wr,
  output logic                issue_ready,
  output logic [NUM_REGS-1:0] busy
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [CW-1:0]       pend [NUM_REGS];
  logic [NUM_REGS-1:0] at_max;
  logic [NUM_REGS-1:0] nonzero;
  logic                fire;
  logic                wb_valid;
  logic                haz1;
  logic                haz2;
  logic                overflow;

  assign wb_valid = regwrite && (wr != '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_valid) begin
      regs[wr] <= wd;
    end
  end

  assign pend[0]    = '0;
  assign at_max[0]  = 1'b0;
  assign nonzero[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_pend
    logic inc;
    logic dec;

    assign inc = fire && issue_wen && (issue_wr == AW'(r));
    assign dec = regwrite && (wr == AW'(r));

    pend_counter #(
      .MAX_PEND (MAX_PEND)
    ) u_pend (
      .clock   (clock),
      .clear   (reset),
      .inc     (inc),
      .dec     (dec),
      .count   (pend[r]),
      .at_max  (at_max[r]),
      .nonzero (nonzero[r])
    );
  end

  assign busy = nonzero;

`ifdef RF_BYPASS_EN
  // The last outstanding write lands this cycle and is forwarded, so it no longer blocks the reader.
  assign haz1 = nonzero[rr1] && !(regwrite && (wr == rr1) && (pend[rr1] == CW'(1)));
  assign haz2 = nonzero[rr2] && !(regwrite && (wr == rr2) && (pend[rr2] == CW'(1)));

  always_comb begin
    rd1 = (rr1 == '0) ? '0 : regs[rr1];
    rd2 = (rr2 == '0) ? '0 : regs[rr2];
    if (wb_valid && (wr == rr1)) rd1 = wd;
    if (wb_valid && (wr == rr2)) rd2 = wd;
  end
`else
  logic unused_pend;

  assign unused_pend = ^{pend[rr1], pend[rr2]};
  assign haz1        = nonzero[rr1];
  assign haz2        = nonzero[rr2];

  always_comb begin
    rd1 = (rr1 == '0) ? '0 : regs[rr1];
    rd2 = (rr2 == '0) ? '0 : regs[rr2];
  end
`endif

  assign overflow    = issue_wen && (issue_wr != '0) && at_max[issue_wr];
  assign issue_ready = !issue_valid ||
                       !((issue_use_rs && haz1) || (issue_use_rt && haz2) || overflow);
  assign fire        = issue_valid && issue_ready;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: expectations are queued with each stimulus
// cycle and compared against the DUT outputs half a clock later.
module tb_regfile_scoreboard;
  import rf_pkg::*;

  localparam int KIND_RD1   = 0;
  localparam int KIND_RD2   = 1;
  localparam int KIND_BUSY  = 2;
  localparam int KIND_READY = 3;

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] val;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset;
  reg_idx_t   rr1, rr2, wr, issue_wr;
  data_t      rd1, rd2, wd;
  logic       regwrite, issue_valid, issue_use_rs, issue_use_rt, issue_wen, issue_ready;
  logic [3:0] busy;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  regfile_scoreboard dut (
    .clock        (clock),
    .reset        (reset),
    .rr1          (rr1),
    .rr2          (rr2),
    .rd1          (rd1),
    .rd2          (rd2),
    .regwrite     (regwrite),
    .wr           (wr),
    .wd           (wd),
    .issue_valid  (issue_valid),
    .issue_use_rs (issue_use_rs),
    .issue_use_rt (issue_use_rt),
    .issue_wen    (issue_wen),
    .issue_wr     (issue_wr),
    .issue_ready  (issue_ready),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, want);
    end
  endtask

  task automatic applyStimulus(input logic rw, input reg_idx_t w, input data_t d,
                               input logic iv, input logic urs, input logic urt,
                               input logic iwen, input reg_idx_t iwr,
                               input reg_idx_t r1, input reg_idx_t r2);
    regwrite     = rw;
    wr           = w;
    wd           = d;
    issue_valid  = iv;
    issue_use_rs = urs;
    issue_use_rt = urt;
    issue_wen    = iwen;
    issue_wr     = iwr;
    rr1          = r1;
    rr2          = r2;
  endtask

  task automatic idle(input reg_idx_t r1, input reg_idx_t r2);
    applyStimulus(1'b0, 2'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, r1, r2);
  endtask

  task automatic expectOut(input string tag, input int kind, input logic [31:0] val);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  // Compare everything queued for this cycle at the falling edge, then cross the next rising edge.
  task automatic runCycle();
    exp_t        e;
    logic [31:0] got;
    @(negedge clock);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.kind)
        KIND_RD1:  got = 32'(rd1);
        KIND_RD2:  got = 32'(rd2);
        KIND_BUSY: got = 32'(busy);
        default:   got = 32'(issue_ready);
      endcase
      checkOutput(e.tag, got, e.val);
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    idle(2'd0, 2'd0);
    runCycle();
    runCycle();
    reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      idle(reset_idx(i), reset_idx(3 - i));
      expectOut($sformatf("reset_rd1_r%0d", i), KIND_RD1, 0);
      expectOut($sformatf("reset_rd2_r%0d", 3 - i), KIND_RD2, 0);
      expectOut("reset_busy", KIND_BUSY, 0);
      expectOut("reset_ready", KIND_READY, 1);
      runCycle();
    end

    applyStimulus(1'b1, 2'd0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
    expectOut("r0_write_same", KIND_RD1, 0);
    runCycle();
    idle(2'd0, 2'd0);
    expectOut("r0_write_after", KIND_RD1, 0);
    runCycle();

    applyStimulus(1'b1, 2'd1, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd1);
    expectOut("wr1_same_cycle_rd1", KIND_RD1, BYP ? 32'h000F : 32'h0);
    expectOut("wr1_same_cycle_rd2", KIND_RD2, BYP ? 32'h000F : 32'h0);
    runCycle();
    idle(2'd1, 2'd1);
    expectOut("wr1_next_rd1", KIND_RD1, 32'h000F);
    expectOut("wr1_next_rd2", KIND_RD2, 32'h000F);
    runCycle();

    applyStimulus(1'b0, 2'd0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0, 2'd0);
    expectOut("issue_r2_ready", KIND_READY, 1);
    runCycle();
    idle(2'd0, 2'd0);
    expectOut("issue_r2_busy", KIND_BUSY, 32'b0100);
    runCycle();
    applyStimulus(1'b0, 2'd0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd2, 2'd0);
    expectOut("raw_stall_0", KIND_READY, 0);
    runCycle();
    expectOut("raw_stall_1", KIND_READY, 0);
    runCycle();
    applyStimulus(1'b1, 2'd2, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd2, 2'd0);
    expectOut("raw_wb_cycle_ready", KIND_READY, BYP ? 1 : 0);
    expectOut("raw_wb_cycle_rd1", KIND_RD1, BYP ? 32'h1234 : 32'h0);
    runCycle();
    applyStimulus(1'b0, 2'd0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd2, 2'd0);
    expectOut("raw_after_wb_ready", KIND_READY, 1);
    expectOut("raw_after_wb_busy", KIND_BUSY, 0);
    expectOut("raw_after_wb_rd1", KIND_RD1, 32'h1234);
    runCycle();

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 2'd0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 2'd0, 2'd0);
      expectOut($sformatf("waw_issue_%0d", i), KIND_READY, 1);
      runCycle();
    end
    expectOut("ovf_stall", KIND_READY, 0);
    expectOut("ovf_busy", KIND_BUSY, 32'b1000);
    runCycle();
    applyStimulus(1'b1, 2'd3, 16'h0333, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 2'd0, 2'd0);
    expectOut("ovf_wb_cycle_stall", KIND_READY, 0);
    runCycle();
    applyStimulus(1'b0, 2'd0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 2'd0, 2'd0);
    expectOut("ovf_after_wb_ready", KIND_READY, 1);
    runCycle();
    expectOut("ovf_refilled_stall", KIND_READY, 0);
    runCycle();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 2'd3, 16'h0300 + 16'(i), 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd3, 2'd0);
      expectOut($sformatf("drain_busy_%0d", i), KIND_BUSY, 32'b1000);
      runCycle();
    end
    applyStimulus(1'b1, 2'd3, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd3, 2'd0);
    expectOut("drained_busy", KIND_BUSY, 0);
    runCycle();
    idle(2'd3, 2'd0);
    expectOut("spurious_wb_busy", KIND_BUSY, 0);
    expectOut("spurious_wb_data", KIND_RD1, 32'hBEEF);
    runCycle();

    applyStimulus(1'b0, 2'd0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 2'd0);
    runCycle();
    applyStimulus(1'b1, 2'd1, 16'h0111, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 2'd0);
    expectOut("incdec_ready", KIND_READY, 1);
    runCycle();
    idle(2'd0, 2'd0);
    expectOut("incdec_busy", KIND_BUSY, 32'b0010);
    runCycle();
    applyStimulus(1'b1, 2'd1, 16'h0112, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
    runCycle();
    idle(2'd0, 2'd0);
    expectOut("incdec_cleared", KIND_BUSY, 0);
    runCycle();

    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 2'd0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 2'd0);
      runCycle();
    end
    idle(2'd1, 2'd3);
    expectOut("pre_reset_busy", KIND_BUSY, 32'b0010);
    reset = 1'b1;
    runCycle();
    reset = 1'b0;
    expectOut("mid_reset_busy", KIND_BUSY, 0);
    expectOut("mid_reset_rd1", KIND_RD1, 0);
    expectOut("mid_reset_rd2", KIND_RD2, 0);
    expectOut("mid_reset_ready", KIND_READY, 1);
    runCycle();
    applyStimulus(1'b1, 2'd1, 16'h0016, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd0);
    runCycle();
    idle(2'd1, 2'd0);
    expectOut("post_reset_wb_data", KIND_RD1, 32'h0016);
    expectOut("post_reset_wb_busy", KIND_BUSY, 0);
    runCycle();
    applyStimulus(1'b0, 2'd0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 2'd0);
    runCycle();
    applyStimulus(1'b1, 2'd1, 16'h0017, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
    expectOut("floor_one_pending", KIND_BUSY, 32'b0010);
    runCycle();
    idle(2'd1, 2'd0);
    expectOut("floor_resolved", KIND_BUSY, 0);
    runCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  function automatic reg_idx_t reset_idx(input int i);
    return reg_idx_t'(i);
  endfunction

endmodule
